// File: rtl/mem_port_arbiter_if.sv
// Shared-port request/grant bundle between the four requesters and the arbiter.
// The arbiter takes the slave view; the requester side (or a bench) takes master.
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempted;

    modport slave  (input  req, output gnt, output sel, output busy, output preempted);
    modport master (output req, input  gnt, input  sel, input  busy, input  preempted);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port with four requesters.
// Ownership is bounded by a hold limit, and every release inserts one idle turnaround cycle.
module mem_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pre_q, pre_d;
    logic               busy_q, busy_d;

    logic [3:0]         rot_req;
    logic [1:0]         win_ofs;
    logic [1:0]         winner;
    logic [3:0]         owner_oh;
    logic               others_waiting;

    // rot_req[k] is the request k+1 positions after the pointer, so bit 0 has top priority.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = bus.req[2'(ptr_q + 2'(gi + 1))];
    end

    always_comb begin
        win_ofs = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_ofs = 2'(k);
            end
        end
    end

    assign winner         = 2'(ptr_q + win_ofs + 2'd1);
    assign owner_oh       = 4'b0001 << sel_q;
    assign others_waiting = |(bus.req & ~owner_oh);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (bus.req != 4'b0000) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    ptr_d   = winner;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end else if (cnt_q == HOLD_LAST) begin
                    if (others_waiting) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        pre_d   = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            pre_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.preempted = pre_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A uses a hold limit of 4, instance B the default 16.
// Expected port values are queued as each cycle's stimulus is driven and popped after the edge.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } obs_t;

    logic clk;
    logic reset;
    obs_t exp_q[$];
    int   checks;
    int   passes;

    mem_port_arbiter_if ifa ();
    mem_port_arbiter_if ifb ();

    mem_port_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    mem_port_arbiter dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // owner < 0 means the port is unowned in that cycle
    function automatic obs_t mk(input int owner, input int sel, input bit pre);
        obs_t r;
        r.gnt  = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
        r.sel  = 2'(sel);
        r.busy = (owner >= 0);
        r.pre  = pre;
        return r;
    endfunction

    function automatic obs_t obs_a();
        return {ifa.gnt, ifa.sel, ifa.busy, ifa.preempted};
    endfunction

    function automatic obs_t obs_b();
        return {ifb.gnt, ifb.sel, ifb.busy, ifb.preempted};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        reset   = 1'b1;
        ifa.req = 4'b1111;
        ifb.req = 4'b1111;
        step();
        step();
        e = mk(-1, 0, 0);
        o = obs_a();
        checks++;
        if (o !== e) $display("FAIL reset_a: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                              o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
        else passes++;
        o = obs_b();
        checks++;
        if (o !== e) $display("FAIL reset_b: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                              o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
        else passes++;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        reset   = 1'b0;
        $display("test_reset done");
    endtask

    // req=0001 for four sampled edges, then dropped; grant lags request by one cycle
    task automatic test_basic();
        obs_t e, o;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            ifb.req = (c < 4) ? 4'b0001 : 4'b0000;
            exp_q.push_back((c < 4) ? mk(0, 0, 0) : mk(-1, 0, 0));
            step();
            e = exp_q.pop_front();
            o = obs_b();
            checks++;
            if (o !== e) $display("FAIL basic cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        $display("test_basic done");
    endtask

    // All four requesting with hold limit 4: four granted cycles, one preempt idle, next in turn
    task automatic test_round_robin();
        obs_t e, o;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            int k, ph;
            k  = c / 5;
            ph = c % 5;
            ifa.req = (c < 25) ? 4'b1111 : 4'b0000;
            if (c == 25)     exp_q.push_back(mk(-1, 0, 0));
            else if (ph < 4) exp_q.push_back(mk(k % 4, k % 4, 0));
            else             exp_q.push_back(mk(-1, k % 4, 1));
            step();
            e = exp_q.pop_front();
            o = obs_a();
            checks++;
            if (o !== e) $display("FAIL round_robin cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        $display("test_round_robin done");
    endtask

    // A lone requester keeps the port across hold-limit boundaries with no gaps
    task automatic test_long_hold();
        obs_t e, o;
        do_reset();
        for (int c = 0; c < 41; c++) begin
            ifb.req = (c < 40) ? 4'b0100 : 4'b0000;
            exp_q.push_back((c < 40) ? mk(2, 2, 0) : mk(-1, 2, 0));
            step();
            e = exp_q.pop_front();
            o = obs_b();
            checks++;
            if (o !== e) $display("FAIL long_hold cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        $display("test_long_hold done");
    endtask

    // Owner 1 drops after three granted cycles; requester 3 follows after one idle cycle
    task automatic test_normal_release();
        obs_t e, o;
        logic [3:0] req_seq [6];
        obs_t       exp_seq [6];
        req_seq = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
        exp_seq = '{mk(1, 1, 0), mk(1, 1, 0), mk(1, 1, 0), mk(-1, 1, 0), mk(3, 3, 0), mk(-1, 3, 0)};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            ifb.req = req_seq[c];
            exp_q.push_back(exp_seq[c]);
            step();
            e = exp_q.pop_front();
            o = obs_b();
            checks++;
            if (o !== e) $display("FAIL normal_release cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        $display("test_normal_release done");
    endtask

    // Owner drops in the same cycle the limit is reached: plain release, no preempt pulse
    task automatic test_limit_drop();
        obs_t e, o;
        logic [3:0] req_seq [7];
        obs_t       exp_seq [7];
        req_seq = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000};
        exp_seq = '{mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0),
                    mk(-1, 0, 0), mk(2, 2, 0), mk(-1, 2, 0)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            ifa.req = req_seq[c];
            exp_q.push_back(exp_seq[c]);
            step();
            e = exp_q.pop_front();
            o = obs_a();
            checks++;
            if (o !== e) $display("FAIL limit_drop cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        $display("test_limit_drop done");
    endtask

    // Reset in the middle of a grant to requester 2, then everyone requests
    task automatic test_reset_mid_grant();
        obs_t e, o;
        logic [3:0] req_seq [5];
        logic       rst_seq [5];
        obs_t       exp_seq [5];
        req_seq = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b0000};
        rst_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_seq = '{mk(2, 2, 0), mk(2, 2, 0), mk(-1, 0, 0), mk(0, 0, 0), mk(-1, 0, 0)};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ifb.req = req_seq[c];
            reset   = rst_seq[c];
            exp_q.push_back(exp_seq[c]);
            step();
            e = exp_q.pop_front();
            o = obs_b();
            checks++;
            if (o !== e) $display("FAIL reset_mid_grant cyc%0d: got gnt=%b sel=%0d busy=%b pre=%b, want gnt=%b sel=%0d busy=%b pre=%b",
                                  c, o.gnt, o.sel, o.busy, o.pre, e.gnt, e.sel, e.busy, e.pre);
            else passes++;
        end
        reset = 1'b0;
        $display("test_reset_mid_grant done");
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        reset   = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        #2;
        test_reset();
        test_basic();
        test_round_robin();
        test_long_hold();
        test_normal_release();
        test_limit_drop();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory/bus port among four requesters: instruction fetch, data access, debug unit, DMA/loader.
- Produces a one-hot grant and a registered 2-bit select that drives the shared 4:1 port mux (sel 0..3 → in0..in3).
- Bounds ownership with a hold limit, so no requester can starve the others.

Parameters:
- MAX_HOLD, 16, maximum consecutive granted cycles before forced release when another requester is waiting; legal range 2..2^CNT_W.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i; level-sensitive; held high for as long as the port is wanted.
- gnt  output  4  registered one-hot grant; all zero when the port is unowned.
- sel  output  2  registered mux select; index of current or most recent owner.
- busy  output  1  registered; 1 while any gnt bit is set.
- preempted  output  1  registered one-cycle pulse; the previous owner was forced off by the hold limit.

Behaviour:
- Reset (reset=1 sampled at a rising edge):
  - gnt=0000, sel=00, busy=0, preempted=0.
  - hold counter = 0; FSM = IDLE; priority pointer ptr = 3, so requester 0 is first in line.
  - Reset overrides everything, including an active grant.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - gnt=0 and busy=0.
  - If req != 0 at an edge, select the winner w as the first set bit in scan order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next cycle: gnt = one-hot(w), sel = w, ptr = w, hold counter = 0, state = BUSY.
  - Latency from request to grant is 1 cycle.
  - If req == 0, remain in IDLE; sel keeps its last value.
- BUSY with owner o; the hold counter counts granted cycles minus 1:
  - req[o]=0 → normal release. Next cycle: IDLE, gnt=0, preempted=0.
  - req[o]=1, counter == MAX_HOLD-1, and (req & ~onehot(o)) != 0 → forced release. Next cycle: IDLE, gnt=0, preempted=1.
  - req[o]=1, counter == MAX_HOLD-1, and no other request → stay BUSY, counter = 0, no preempt.
  - Otherwise → stay BUSY, counter + 1.
- Release always costs one idle cycle (gnt=0) before the next grant. This is the bus turnaround; back-to-back grants never occur.
- preempted is high only for the single IDLE cycle after a forced release, and 0 in every other cycle.
- Simultaneous events:
  - req[o] drops in the same cycle the limit is reached → normal release; preempted=0.
  - A new request arriving during BUSY is ignored until the next IDLE.
- sel changes only on a grant and never while gnt != 0, so the mux select is stable for the whole ownership.
- Invariants: gnt has at most one bit set; busy == |gnt; when gnt != 0, gnt == one-hot(sel).
- The counter is CNT_W bits wide and is compared for equality only; it never wraps while in BUSY.

Test Plan:
- Reset, then req=0001 from cycle 2 → gnt=0001, sel=0, busy=1 from cycle 3; req=0000 at cycle 6 → gnt=0000 from cycle 7; preempted stays 0.
- MAX_HOLD=4, req=1111 held:
  - grants go 0,1,2,3,0, each exactly 4 cycles;
  - each grant is separated by one cycle of gnt=0 with preempted=1;
  - sel follows 0,1,2,3,0.
- MAX_HOLD=16, req=0100 only, held 40 cycles → gnt=0100 continuously for 40 cycles, no idle gaps, preempted never asserted.
- Owner 1 granted, req=1010, req[1] drops after its 3rd granted cycle → one idle cycle, then gnt=1000, sel=3, preempted=0.
- MAX_HOLD=4, owner 0 with req[2]=1; req[0] drops exactly in the 4th granted cycle → normal release, preempted=0, next gnt=0100.
- Owner 2 mid-grant (gnt=0100), reset pulsed 1 cycle:
  - next cycle gnt=0, sel=0, busy=0;
  - with req=1111 afterwards, the first grant goes to requester 0.
